// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges an instruction-fetch master (m0) and a data
// master (m1) onto one memory slave port. Round-robin grant, locked while a
// request is presented but not yet accepted. A small owner FIFO remembers
// which master issued each outstanding read so in-order responses can be
// steered back to the right master.
//
// Handshake: a request transfers in the cycle where valid && ready are both
// high. A master keeps valid and every request field stable until it sees its
// ready. Reads return exactly one s_rvalid pulse, in issue order. Writes
// return nothing.
module mem_port_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // master 0 (instruction fetch)
  input  logic        m0_valid_i,
  output logic        m0_ready_o,
  input  logic        m0_write_en_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_byte_en_i,
  output logic [31:0] m0_rdata_o,
  output logic        m0_rvalid_o,
  // master 1 (data)
  input  logic        m1_valid_i,
  output logic        m1_ready_o,
  input  logic        m1_write_en_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_byte_en_i,
  output logic [31:0] m1_rdata_o,
  output logic        m1_rvalid_o,
  // slave
  output logic        s_valid_o,
  input  logic        s_ready_i,
  output logic        s_write_en_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_byte_en_o,
  input  logic [31:0] s_rdata_i,
  input  logic        s_rvalid_i,
  // status / debug
  output logic        resp_err_o,
  output logic [$clog2(DEPTH+1)-1:0] dbg_count_o,
  output logic        dbg_lock_valid_o,
  output logic        dbg_last_grant_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             last_grant_q, last_grant_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_owner_q, lock_owner_d;
  logic             resp_err_q,   resp_err_d;
  logic [DEPTH-1:0] owner_q,      owner_d;
  logic [PTR_W-1:0] head_q,       head_d;
  logic [PTR_W-1:0] tail_q,       tail_d;
  logic [CNT_W-1:0] count_q,      count_d;

  logic        grant_any;
  logic        grant;
  logic        g_valid;
  logic        g_write_en;
  logic        fifo_full;
  logic        blocked;
  logic        xfer;
  logic        push;
  logic        pop;
  logic        head_owner;

  // Grant selection: a lock wins, then a lone requester, then round-robin.
  always_comb begin
    grant_any = 1'b0;
    grant     = 1'b0;
    if (lock_valid_q) begin
      grant_any = 1'b1;
      grant     = lock_owner_q;
    end else if (m0_valid_i && m1_valid_i) begin
      grant_any = 1'b1;
      grant     = ~last_grant_q;
    end else if (m0_valid_i) begin
      grant_any = 1'b1;
      grant     = 1'b0;
    end else if (m1_valid_i) begin
      grant_any = 1'b1;
      grant     = 1'b1;
    end
  end

  // Request forwarding and read stall; reads are held off while the owner
  // FIFO is full, with no credit for a pop happening in the same cycle.
  always_comb begin
    g_valid      = grant ? m1_valid_i    : m0_valid_i;
    g_write_en   = grant ? m1_write_en_i : m0_write_en_i;
    s_write_en_o = g_write_en;
    s_addr_o     = grant ? m1_addr_i    : m0_addr_i;
    s_wdata_o    = grant ? m1_wdata_i   : m0_wdata_i;
    s_byte_en_o  = grant ? m1_byte_en_i : m0_byte_en_i;
    fifo_full    = (count_q == CNT_W'(DEPTH));
    blocked      = grant_any && !g_write_en && fifo_full;
    s_valid_o    = grant_any && g_valid && !blocked;
    xfer         = s_valid_o && s_ready_i;
    m0_ready_o   = xfer && (grant == 1'b0);
    m1_ready_o   = xfer && (grant == 1'b1);
    push         = xfer && !g_write_en;
  end

  // Response steering from the FIFO head; a response with nothing
  // outstanding is dropped and flagged.
  always_comb begin
    head_owner  = owner_q[head_q];
    pop         = s_rvalid_i && (count_q != '0);
    m0_rvalid_o = pop && !head_owner;
    m1_rvalid_o = pop &&  head_owner;
    m0_rdata_o  = s_rdata_i;
    m1_rdata_o  = s_rdata_i;
  end

  // Next-state for grant history, lock, owner FIFO and the error flag.
  always_comb begin
    last_grant_d = last_grant_q;
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    resp_err_d   = resp_err_q;
    owner_d      = owner_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;

    if (xfer) begin
      last_grant_d = grant;
      lock_valid_d = 1'b0;
    end else if (s_valid_o) begin
      lock_valid_d = 1'b1;
      lock_owner_d = grant;
    end

    if (push) begin
      owner_d[tail_q] = grant;
      tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    if (s_rvalid_i && (count_q == '0)) begin
      resp_err_d = 1'b1;
    end
  end

  // State registers with synchronous reset; last_grant starts at 1 so m0
  // wins the first contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
      lock_valid_q <= 1'b0;
      lock_owner_q <= 1'b0;
      resp_err_q   <= 1'b0;
      owner_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      resp_err_q   <= resp_err_d;
      owner_q      <= owner_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  assign resp_err_o       = resp_err_q;
  assign dbg_count_o      = count_q;
  assign dbg_lock_valid_o = lock_valid_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (DEPTH = 4). Inputs change just after
// the falling edge, outputs are sampled 1 ns later, state advances on the
// following rising edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m0_ready, m0_write_en, m0_rvalid;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_byte_en;
  logic        m1_valid, m1_ready, m1_write_en, m1_rvalid;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_byte_en;
  logic        s_valid, s_ready, s_write_en, s_rvalid;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_byte_en;
  logic        resp_err;
  logic [2:0]  dbg_count;
  logic        dbg_lock_valid, dbg_last_grant;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_valid_i(m0_valid), .m0_ready_o(m0_ready), .m0_write_en_i(m0_write_en),
    .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata), .m0_byte_en_i(m0_byte_en),
    .m0_rdata_o(m0_rdata), .m0_rvalid_o(m0_rvalid),
    .m1_valid_i(m1_valid), .m1_ready_o(m1_ready), .m1_write_en_i(m1_write_en),
    .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata), .m1_byte_en_i(m1_byte_en),
    .m1_rdata_o(m1_rdata), .m1_rvalid_o(m1_rvalid),
    .s_valid_o(s_valid), .s_ready_i(s_ready), .s_write_en_o(s_write_en),
    .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_byte_en_o(s_byte_en),
    .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid),
    .resp_err_o(resp_err), .dbg_count_o(dbg_count),
    .dbg_lock_valid_o(dbg_lock_valid), .dbg_last_grant_o(dbg_last_grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_valid = 0; m0_write_en = 0; m0_addr = 0; m0_wdata = 0; m0_byte_en = 0;
    m1_valid = 0; m1_write_en = 0; m1_addr = 0; m1_wdata = 0; m1_byte_en = 0;
    s_ready = 0; s_rvalid = 0; s_rdata = 0;
  endtask

  task automatic do_reset();
    tick(); idle(); rst = 1;
    tick(); rst = 0;
  endtask

  task automatic m0_req(input logic we, input logic [31:0] addr);
    m0_valid = 1; m0_write_en = we; m0_addr = addr; m0_wdata = ~addr; m0_byte_en = 4'hF;
  endtask

  task automatic m1_req(input logic we, input logic [31:0] addr);
    m1_valid = 1; m1_write_en = we; m1_addr = addr; m1_wdata = ~addr; m1_byte_en = 4'h3;
  endtask

  initial begin
    logic [31:0] a0, a1;
    idle(); rst = 1;
    do_reset();

    // Reset state
    #1;
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m0_ready", m0_ready, 0);
    chk("rst_m1_ready", m1_ready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_count", dbg_count, 0);

    // Single read from m0
    tick(); m0_req(0, 32'h100); s_ready = 1; #1;
    chk("rd_s_valid", s_valid, 1);
    chk("rd_s_addr", s_addr, 32'h100);
    chk("rd_s_we", s_write_en, 0);
    chk("rd_m0_ready", m0_ready, 1);
    chk("rd_m1_ready", m1_ready, 0);
    tick(); idle(); #1;
    chk("rd_count1", dbg_count, 1);
    tick(); s_rvalid = 1; s_rdata = 32'hDEADBEEF; #1;
    chk("rd_m0_rvalid", m0_rvalid, 1);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
    tick(); idle(); #1;
    chk("rd_count0", dbg_count, 0);
    chk("rd_no_err", resp_err, 0);

    // Contention: grants alternate m0, m1, m0, m1
    do_reset();
    a0 = 32'h200; a1 = 32'h300;
    for (int i = 0; i < 4; i++) begin
      m0_req(0, a0); m1_req(0, a1); s_ready = 1; #1;
      chk("cont_s_addr", s_addr, (i % 2 == 0) ? a0 : a1);
      chk("cont_m0_ready", m0_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_m1_ready", m1_ready, (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) a0 = a0 + 4; else a1 = a1 + 4;
      tick();
    end
    idle(); #1;
    chk("cont_count4", dbg_count, 4);
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1; s_rdata = 32'hA0 + i; #1;
      chk("cont_m0_rvalid", m0_rvalid, (i % 2 == 0) ? 1 : 0);
      chk("cont_m1_rvalid", m1_rvalid, (i % 2 == 0) ? 0 : 1);
      chk("cont_rdata", m1_rdata, 32'hA0 + i);
      tick();
    end
    idle(); #1;
    chk("cont_count0", dbg_count, 0);

    // Lock: m0 presented while slave stalls
    do_reset();
    m0_req(1, 32'h400); m1_req(1, 32'h500); s_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock_s_valid", s_valid, 1);
      chk("lock_s_addr", s_addr, 32'h400);
      chk("lock_m0_ready", m0_ready, 0);
      chk("lock_m1_ready", m1_ready, 0);
      tick();
    end
    s_ready = 1; #1;
    chk("lock_rel_addr", s_addr, 32'h400);
    chk("lock_rel_m0_ready", m0_ready, 1);
    chk("lock_rel_m1_ready", m1_ready, 0);
    tick(); m0_req(1, 32'h404); #1;
    chk("lock_next_addr", s_addr, 32'h500);
    chk("lock_next_m1_ready", m1_ready, 1);
    chk("lock_next_m0_ready", m0_ready, 0);
    // m1 locks alone; m0 then arrives but the lock holds against round-robin
    tick(); m0_valid = 0; m1_req(1, 32'h504); s_ready = 0; #1;
    chk("lock1_s_addr", s_addr, 32'h504);
    tick(); m0_req(1, 32'h404); #1;
    chk("lock1_hold_addr", s_addr, 32'h504);
    chk("lock1_hold_m0_ready", m0_ready, 0);
    tick(); s_ready = 1; #1;
    chk("lock1_rel_m1_ready", m1_ready, 1);
    tick(); m1_valid = 0; #1;
    chk("lock1_after_addr", s_addr, 32'h404);
    chk("lock1_after_m0_ready", m0_ready, 1);
    tick(); idle();

    // Full FIFO: 4 outstanding reads stall a 5th read, writes still pass
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_req(0, 32'h600 + 4 * i); s_ready = 1; #1;
      chk("full_fill_ready", m0_ready, 1);
      tick();
    end
    m0_req(0, 32'h610); #1;
    chk("full_count", dbg_count, 4);
    chk("full_blk_s_valid", s_valid, 0);
    chk("full_blk_m0_ready", m0_ready, 0);
    tick(); m1_req(1, 32'h700); #1;
    chk("full_wr_s_valid", s_valid, 1);
    chk("full_wr_s_addr", s_addr, 32'h700);
    chk("full_wr_m1_ready", m1_ready, 1);
    chk("full_wr_m0_ready", m0_ready, 0);
    tick(); m1_valid = 0; s_rvalid = 1; s_rdata = 32'h55; #1;
    chk("full_nobypass_s_valid", s_valid, 0);
    chk("full_pop_m0_rvalid", m0_rvalid, 1);
    tick(); s_rvalid = 0; #1;
    chk("full_resume_s_valid", s_valid, 1);
    chk("full_resume_addr", s_addr, 32'h610);
    chk("full_resume_m0_ready", m0_ready, 1);
    tick(); idle(); #1;
    chk("full_count_after", dbg_count, 4);

    // Writes only, alternating masters
    do_reset();
    for (int i = 0; i < 10; i++) begin
      idle(); s_ready = 1;
      if (i % 2 == 0) m0_req(1, 32'h800 + i); else m1_req(1, 32'h900 + i);
      #1;
      chk("wr_s_we", s_write_en, 1);
      chk("wr_ready", (i % 2 == 0) ? m0_ready : m1_ready, 1);
      chk("wr_rvalid", {m0_rvalid, m1_rvalid}, 0);
      tick();
    end
    idle(); #1;
    chk("wr_count", dbg_count, 0);

    // Spurious response, then reset with reads outstanding
    do_reset();
    s_rvalid = 1; s_rdata = 32'h1234; #1;
    chk("sp_m0_rvalid", m0_rvalid, 0);
    chk("sp_m1_rvalid", m1_rvalid, 0);
    tick(); s_rvalid = 0; #1;
    chk("sp_err_set", resp_err, 1);
    tick(); #1;
    chk("sp_err_sticky", resp_err, 1);
    do_reset(); #1;
    chk("sp_err_clr", resp_err, 0);
    for (int i = 0; i < 2; i++) begin
      m0_req(0, 32'hA00 + 4 * i); s_ready = 1;
      tick();
    end
    idle(); #1;
    chk("sp_count2", dbg_count, 2);
    do_reset(); #1;
    chk("sp_count_rst", dbg_count, 0);
    s_rvalid = 1; #1;
    chk("sp_post_m0_rvalid", m0_rvalid, 0);
    tick(); s_rvalid = 0; #1;
    chk("sp_post_err", resp_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master to one-slave arbiter for the core's memory ports. It merges the instruction-fetch master (m0) and the data master (m1) onto a single memory slave port. Grants are round-robin, and a grant stays locked for the whole request handshake. The block records the owner of every outstanding read so that in-order read responses return to the master that issued them. It sits between the core wrapper's two master ports and the single SRAM/bus slave.

## Interface
- DEPTH, default 4: maximum outstanding reads; width of the response-owner FIFO (must be ≥1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mN_valid  in  1  request valid from master N (N = 0, 1).
- mN_ready  out  1  request accepted from master N this cycle.
- mN_write_en  in  1  1 = write, 0 = read.
- mN_addr  in  32  byte address.
- mN_wdata  in  32  write data.
- mN_byte_en  in  4  write byte enables.
- mN_rdata  out  32  read data; copy of s_rdata to both masters.
- mN_rvalid  out  1  read response for master N.
- s_valid  out  1  request to the slave.
- s_ready  in  1  slave accepts the request.
- s_write_en, s_addr, s_wdata, s_byte_en  out  1/32/32/4  request fields, muxed from the granted master.
- s_rdata  in  32  read data.
- s_rvalid  in  1  read response; responses arrive in request order.
- resp_err  out  1  sticky flag: s_rvalid was seen with no outstanding read.

## Operation
- Handshake: a request transfers when valid && ready. Masters hold valid and all request fields stable until accepted. Writes produce no response. Each read produces exactly one s_rvalid pulse, at least 1 cycle after acceptance.
- State registers:
  - last_grant (1 bit).
  - lock_valid / lock_owner: a request has been presented to the slave but not yet accepted.
  - owner FIFO: DEPTH entries of 1 bit each, with head/tail pointers and a count of 0..DEPTH.
- Grant selection:
  - If lock_valid, the grant is lock_owner.
  - Otherwise, if only one master is valid, that master wins.
  - If both are valid, the master ≠ last_grant wins.
  - If neither is valid, there is no grant.
- Read stall: the granted request is blocked when it is a read (write_en = 0) and count == DEPTH.
  - While blocked, s_valid = 0 and mN_ready = 0.
  - No same-cycle pop bypass: a read is blocked at full even if s_rvalid pops an entry that cycle.
  - Writes are never blocked.
- Forwarding:
  - s_valid = granted master's valid && !blocked.
  - s_* request fields = granted master's fields.
  - mN_ready = s_ready && s_valid && (grant == N). The non-granted master always sees ready = 0.
- On a transfer:
  - last_grant ← grant and lock_valid ← 0.
  - If the transfer is a read, push grant into the FIFO.
- When s_valid && !s_ready: lock_valid ← 1 and lock_owner ← grant.
- Response routing:
  - On s_rvalid with count > 0: mN_rvalid = 1 for N = FIFO head (combinational), then pop.
  - On s_rvalid with count == 0: no mN_rvalid, no pop, resp_err ← 1.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Reset:
  - count, head and tail = 0; lock_valid = 0; last_grant = 1, so m0 wins the first contention; resp_err = 0.
  - All outputs are combinational functions of this state, so after reset every valid/ready/rvalid output is 0 until inputs request otherwise.
  - A reset mid-transaction discards all outstanding-read ownership. Responses arriving after reset set resp_err.

## Timing
- Request path: zero latency and combinational; mN_valid → s_valid and s_ready → mN_ready in the same cycle.
- Response path: combinational; s_rvalid → mN_rvalid in the same cycle.
- Throughput:
  - One request per cycle when s_ready = 1.
  - Under continuous contention, grants alternate m0, m1, m0, …
- A locked grant holds for as many cycles as s_ready stays low. The other master waits, even if it is higher priority by round-robin.
- The FIFO count updates at the clock edge. A read accepted in cycle t can have its response routed as early as cycle t+1.

## Test plan
- Reset, then single read: m0 read addr 0x100 with s_ready = 1 → s_addr = 0x100 and m0_ready = 1 in the same cycle. A later s_rvalid with s_rdata = 0xDEADBEEF → m0_rvalid = 1, m1_rvalid = 0, m0_rdata = 0xDEADBEEF.
- Contention: both masters valid for 4 cycles with s_ready = 1 → grant order m0, m1, m0, m1. Four in-order responses route to rvalid of m0, m1, m0, m1.
- Lock: both valid, s_ready = 0 for 3 cycles with m0 presented → s_addr stays m0's address and m1_ready = 0 throughout. In the cycle s_ready rises, m0 transfers; m1 is granted the next cycle.
- Full FIFO (DEPTH = 4): issue 4 reads with no responses → the 5th read sees s_valid = 0, while a write from the other master still passes. One s_rvalid → the 5th read transfers the next cycle.
- Writes only: 10 writes alternating masters → FIFO count stays 0 and no mN_rvalid is asserted.
- Spurious response: s_rvalid with an empty FIFO → no mN_rvalid and resp_err = 1 until rst. Asserting rst with 2 reads outstanding → count = 0, and a subsequent s_rvalid sets resp_err.
